// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-word sweep controller: fixed, up, down and triangle profiles with dwell timing.
// Build option SWEEP_CNT_EN adds a saturating counter of completed sweep periods on sweep_count.
module dds_sweep_ctrl #(
   parameter int FREQ_W  = 20,
   parameter int DWELL_W = 24,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               cfg_load,
   input  logic [1:0]         cfg_mode,
   input  logic [FREQ_W-1:0]  cfg_start,
   input  logic [FREQ_W-1:0]  cfg_stop,
   input  logic [FREQ_W-1:0]  cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   output logic [FREQ_W-1:0]  current_freq,
   output logic               sweep_active,
   output logic               step_strobe,
   output logic               sweep_wrap,
   output logic               phase_sync,
   output logic               cfg_err,
   output logic [CNT_W-1:0]   sweep_count
);

   // state   | meaning
   // S_IDLE  | after reset, frequency held until the first cfg_load
   // S_FIXED | fixed mode or rejected range, frequency held
   // S_RUN   | stepping through the configured profile

   typedef enum logic [1:0] {S_IDLE, S_FIXED, S_RUN} state_t;

   localparam logic [1:0] M_FIXED = 2'b00;
   localparam logic [1:0] M_UP    = 2'b01;
   localparam logic [1:0] M_DOWN  = 2'b10;
   localparam logic [1:0] M_TRI   = 2'b11;

   state_t             state;
   logic [1:0]         sh_mode;
   logic [FREQ_W-1:0]  sh_start, sh_stop, sh_step;
   logic [DWELL_W-1:0] sh_dwell;
   logic [DWELL_W-1:0] dwell_cnt;
   logic               dir_down;

   logic [FREQ_W:0]    sum, diff;
   logic [FREQ_W-1:0]  next_freq;
   logic               next_wrap, next_dir_down;
   logic [DWELL_W-1:0] load_reload, run_reload;
   logic               step_evt;

   // dwell counter runs down from D-1; terminal count 0 is the D-th enabled cycle
   assign load_reload = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
   assign run_reload  = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;
   assign step_evt    = !cfg_load && (state == S_RUN) && enable && (dwell_cnt == '0);

   always_comb begin
      sum           = {1'b0, current_freq} + {1'b0, sh_step};
      diff          = {1'b0, current_freq} - {1'b0, sh_step};
      next_freq     = current_freq;
      next_wrap     = 1'b0;
      next_dir_down = dir_down;
      case (sh_mode)
         M_UP: begin
            // start == stop forces a wrap even when a zero step would otherwise hold
            if ((sum > {1'b0, sh_stop}) || (sh_start == sh_stop)) begin
               next_freq = sh_start;
               next_wrap = 1'b1;
            end else begin
               next_freq = sum[FREQ_W-1:0];
            end
         end
         M_DOWN: begin
            if (diff[FREQ_W] || (diff[FREQ_W-1:0] < sh_start) || (sh_start == sh_stop)) begin
               next_freq = sh_stop;
               next_wrap = 1'b1;
            end else begin
               next_freq = diff[FREQ_W-1:0];
            end
         end
         M_TRI: begin
            if (!dir_down) begin
               if (sum >= {1'b0, sh_stop}) begin
                  next_freq     = sh_stop;
                  next_dir_down = 1'b1;
               end else begin
                  next_freq = sum[FREQ_W-1:0];
               end
            end else if (diff[FREQ_W] || (diff[FREQ_W-1:0] <= sh_start)) begin
               next_freq     = sh_start;
               next_dir_down = 1'b0;
               next_wrap     = 1'b1;
            end else begin
               next_freq = diff[FREQ_W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         sh_mode      <= M_FIXED;
         sh_start     <= '0;
         sh_stop      <= '0;
         sh_step      <= '0;
         sh_dwell     <= '0;
         dwell_cnt    <= '0;
         dir_down     <= 1'b0;
         current_freq <= '0;
         sweep_active <= 1'b0;
         step_strobe  <= 1'b0;
         sweep_wrap   <= 1'b0;
         phase_sync   <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         step_strobe <= 1'b0;
         sweep_wrap  <= 1'b0;
         phase_sync  <= 1'b0;
         if (cfg_load) begin
            sh_mode    <= cfg_mode;
            sh_start   <= cfg_start;
            sh_stop    <= cfg_stop;
            sh_step    <= cfg_step;
            sh_dwell   <= cfg_dwell;
            dwell_cnt  <= load_reload;
            dir_down   <= 1'b0;
            phase_sync <= 1'b1;
            if (cfg_mode == M_FIXED) begin
               state        <= S_FIXED;
               current_freq <= cfg_start;
               sweep_active <= 1'b0;
               cfg_err      <= 1'b0;
            end else if (cfg_start <= cfg_stop) begin
               state        <= S_RUN;
               current_freq <= (cfg_mode == M_DOWN) ? cfg_stop : cfg_start;
               sweep_active <= 1'b1;
               cfg_err      <= 1'b0;
            end else begin
               state        <= S_FIXED;
               current_freq <= cfg_start;
               sweep_active <= 1'b0;
               cfg_err      <= 1'b1;
            end
         end else if (step_evt) begin
            dwell_cnt    <= run_reload;
            current_freq <= next_freq;
            dir_down     <= next_dir_down;
            step_strobe  <= 1'b1;
            sweep_wrap   <= next_wrap;
            phase_sync   <= next_wrap;
         end else if ((state == S_RUN) && enable) begin
            dwell_cnt <= dwell_cnt - 1'b1;
         end
      end
   end

`ifdef SWEEP_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || cfg_load) begin
         sweep_count <= '0;
      end else if (step_evt && next_wrap && (sweep_count != '1)) begin
         sweep_count <= sweep_count + 1'b1;
      end
   end
`else
   assign sweep_count = '0;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a period-list reference model predicts every cycle's outputs.
// Honours SWEEP_CNT_EN when predicting sweep_count.
module tb_dds_sweep_ctrl;
   localparam int FREQ_W  = 20;
   localparam int DWELL_W = 24;
   localparam int CNT_W   = 16;
   localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

   logic               clk;
   logic               rst_n;
   logic               enable;
   logic               cfg_load;
   logic [1:0]         cfg_mode;
   logic [FREQ_W-1:0]  cfg_start, cfg_stop, cfg_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [FREQ_W-1:0]  current_freq;
   logic               sweep_active, step_strobe, sweep_wrap, phase_sync, cfg_err;
   logic [CNT_W-1:0]   sweep_count;

   dds_sweep_ctrl #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
      .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .current_freq(current_freq),
      .sweep_active(sweep_active), .step_strobe(step_strobe), .sweep_wrap(sweep_wrap),
      .phase_sync(phase_sync), .cfg_err(cfg_err), .sweep_count(sweep_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint freq;
      bit active, strobe, wrap, psync, err;
      longint cnt;
   } exp_t;

   exp_t   exp_q[$];
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;

`ifdef SWEEP_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   // reference model: one sweep period as a list of frequencies, wrap on return to index 0
   longint seq[$];
   bit     nowrap;
   bit     m_run;
   int     m_pos;
   longint m_en, m_d, m_freq, m_cnt;
   bit     m_active, m_err;

   function automatic void build_seq(input logic [1:0] mode, input longint s, input longint e,
                                     input longint st);
      longint n;
      longint v;
      seq.delete();
      nowrap = 1'b0;
      if (st == 0 && s != e) begin
         seq.push_back(mode == 2'b10 ? e : s);
         nowrap = 1'b1;
      end else if (mode == 2'b01 || mode == 2'b10) begin
         n = (st == 0) ? 1 : (e - s) / st + 1;
         for (longint i = 0; i < n; i++) seq.push_back(mode == 2'b01 ? s + i * st : e - i * st);
      end else begin
         seq.push_back(s);
         v = s + st;
         while (v < e) begin seq.push_back(v); v = v + st; end
         seq.push_back(e);
         v = e - st;
         while (v > s) begin seq.push_back(v); v = v - st; end
      end
   endfunction

   function automatic void model_push();
      exp_t x;
      x.strobe = 1'b0; x.wrap = 1'b0; x.psync = 1'b0;
      if (!rst_n) begin
         m_run = 1'b0; m_freq = 0; m_active = 1'b0; m_err = 1'b0; m_cnt = 0;
      end else if (cfg_load) begin
         m_d = (cfg_dwell == 0) ? 1 : longint'(cfg_dwell);
         m_en = 0; m_pos = 0; m_cnt = 0; x.psync = 1'b1;
         if (cfg_mode == 2'b00) begin
            m_run = 1'b0; m_freq = longint'(cfg_start); m_active = 1'b0; m_err = 1'b0;
         end else if (cfg_start <= cfg_stop) begin
            build_seq(cfg_mode, longint'(cfg_start), longint'(cfg_stop), longint'(cfg_step));
            m_run = 1'b1; m_freq = seq[0]; m_active = 1'b1; m_err = 1'b0;
         end else begin
            m_run = 1'b0; m_freq = longint'(cfg_start); m_active = 1'b0; m_err = 1'b1;
         end
      end else if (m_run && enable) begin
         m_en++;
         if (m_en == m_d) begin
            m_en = 0;
            m_pos = (m_pos + 1) % seq.size();
            m_freq = seq[m_pos];
            x.strobe = 1'b1;
            x.wrap = (m_pos == 0) && !nowrap;
            x.psync = x.wrap;
            if (x.wrap && m_cnt < CNT_MAX) m_cnt++;
         end
      end
      x.freq = m_freq; x.active = m_active; x.err = m_err;
      x.cnt = CNT_ON ? m_cnt : 0;
      exp_q.push_back(x);
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, req);
      end
   endtask

   // monitor: pops one prediction per clock and compares all outputs
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("freq", longint'(current_freq), x.freq);
            check("active", longint'(sweep_active), longint'(x.active));
            check("strobe", longint'(step_strobe), longint'(x.strobe));
            check("wrap", longint'(sweep_wrap), longint'(x.wrap));
            check("phase_sync", longint'(phase_sync), longint'(x.psync));
            check("cfg_err", longint'(cfg_err), longint'(x.err));
            check("count", longint'(sweep_count), x.cnt);
         end
      end
   end

   task automatic tick();
      model_push();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] m, input longint s, input longint e, input longint st,
                       input longint d);
      cfg_mode = m; cfg_start = FREQ_W'(s); cfg_stop = FREQ_W'(e);
      cfg_step = FREQ_W'(st); cfg_dwell = DWELL_W'(d); cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      cfg_mode = 2'($urandom); cfg_start = FREQ_W'($urandom); cfg_stop = FREQ_W'($urandom);
      cfg_step = FREQ_W'($urandom); cfg_dwell = DWELL_W'($urandom);
   endtask

   initial begin
      longint r_start, r_stop, r_step, r_dwell;
      logic [1:0] r_mode;
      int len;
      int k;
      rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; cfg_mode = '0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("idle_freq", longint'(current_freq), 0);
      check("idle_active", longint'(sweep_active), 0);

      enable = 1'b1;
      load(2'b01, 1000, 1300, 100, 4);
      check("up_load_freq", longint'(current_freq), 1000);
      check("up_load_sync", longint'(phase_sync), 1);
      repeat (16) tick();
      check("up_wrap_freq", longint'(current_freq), 1000);
      check("up_wrap_pulse", longint'(sweep_wrap), 1);

      load(2'b11, 0, 250, 100, 1);
      repeat (3) tick();
      check("tri_peak", longint'(current_freq), 250);
      repeat (3) tick();
      check("tri_end", longint'(current_freq), 0);
      check("tri_wrap", longint'(sweep_wrap), 1);

      load(2'b10, 10, 'hFFFFF, 'h80000, 3);
      check("down_load", longint'(current_freq), 'hFFFFF);
      tick();
      enable = 1'b0;
      repeat (7) tick();
      enable = 1'b1;
      tick();
      check("down_frozen", longint'(current_freq), 'hFFFFF);
      tick();
      check("down_step", longint'(current_freq), 'h7FFFF);
      repeat (3) tick();
      check("down_underflow", longint'(current_freq), 'hFFFFF);
      check("down_wrap", longint'(sweep_wrap), 1);

      load(2'b01, 500, 400, 5, 1);
      repeat (100) tick();
      check("bad_range_err", longint'(cfg_err), 1);
      check("bad_range_freq", longint'(current_freq), 500);
      load(2'b00, 42, 7, 3, 2);
      check("fixed_err", longint'(cfg_err), 0);
      check("fixed_freq", longint'(current_freq), 42);

      load(2'b01, 0, 1000, 1, 1);
      repeat (5) tick();
      load(2'b01, 777, 900, 1, 1);
      check("coinc_freq", longint'(current_freq), 777);
      check("coinc_sync", longint'(phase_sync), 1);
      check("coinc_strobe", longint'(step_strobe), 0);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_freq", longint'(current_freq), 0);
      check("rst_active", longint'(sweep_active), 0);

      load(2'b01, 0, 20, 10, 1);
      repeat (9) tick();
      check("count3", longint'(sweep_count), CNT_ON ? 3 : 0);

      load(2'b11, 300, 300, 0, 2);
      repeat (12) tick();
      load(2'b10, 64, 64, 0, 1);
      repeat (6) tick();

      for (int c = 0; c < 30; c++) begin
         r_mode = 2'($urandom_range(0, 3));
         r_start = longint'($urandom_range(0, 'hFFFFF));
         r_stop = r_start + longint'($urandom_range(0, 2000));
         if (r_stop > 'hFFFFF) r_stop = 'hFFFFF;
         if ($urandom_range(0, 4) == 0 && r_start > 0) begin
            r_stop = r_start - 1;
         end
         k = int'($urandom_range(0, 9));
         if (k == 0) r_step = 0;
         else if (k == 1) r_step = longint'($urandom_range(1, 'hFFFFF));
         else r_step = longint'($urandom_range(1, 700));
         r_dwell = longint'($urandom_range(0, 6));
         load(r_mode, r_start, r_stop, r_step, r_dwell);
         len = int'($urandom_range(20, 300));
         for (int j = 0; j < len; j++) begin
            enable = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
         end
         rst_n = 1'b1;
         enable = 1'b1;
      end

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      check("drain", longint'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequences the DDS frequency word for the waveform generator.
- Latches a start/stop/step/dwell sweep configuration and produces `current_freq` for the phase-accumulator datapath.
- Supported profiles: fixed, linear up, linear down, or triangle (up/down).
- Issues a `phase_sync` pulse on every sweep (re)start, so the phase accumulator can be realigned, and reports step and wrap events to the debug probes.

Parameters:
- FREQ_W, 20, width of all frequency words
- DWELL_W, 24, width of the dwell-cycle count
- CNT_W, 16, width of the sweep counter (optional feature only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  1 = sweep runs; 0 = freeze dwell counter and frequency
- cfg_load  in  1  single-cycle pulse; latches all cfg_* inputs and restarts the sweep
- cfg_mode  in  2  00 fixed, 01 up, 10 down, 11 triangle
- cfg_start  in  FREQ_W  lower sweep bound
- cfg_stop  in  FREQ_W  upper sweep bound
- cfg_step  in  FREQ_W  frequency increment per step
- cfg_dwell  in  DWELL_W  cycles per step; 0 is treated as 1
- current_freq  out  FREQ_W  frequency word to the DDS
- sweep_active  out  1  a stepping mode is running and the config is valid
- step_strobe  out  1  1-cycle pulse, coincident with each current_freq update caused by a step
- sweep_wrap  out  1  1-cycle pulse at the end of each sweep period
- phase_sync  out  1  1-cycle pulse on cfg_load restart and on each sweep_wrap
- cfg_err  out  1  start > stop in a stepping mode; holds until the next cfg_load
- sweep_count  out  CNT_W  completed sweep periods (optional feature)

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, shadow config cleared to 0, direction = up. Reset mid-sweep aborts immediately.
- Configuration is used only from the shadow registers. Changes on cfg_* without cfg_load have no effect.
- States:
  - IDLE: entered after reset; current_freq holds. Exits only on cfg_load.
  - FIXED: mode 00, or an invalid range.
  - RUN: any stepping mode with a valid range.
- cfg_load at edge N (highest priority, any state, any enable value):
  - Shadow registers latch at N.
  - At N+1: current_freq = cfg_start (mode 10: cfg_stop), dwell counter = 0, direction = up, phase_sync = 1.
  - Mode 00 → FIXED, sweep_active = 0.
  - Modes 01–11 with start ≤ stop → RUN, sweep_active = 1, cfg_err = 0.
  - Modes 01–11 with start > stop → FIXED at cfg_start, cfg_err = 1, sweep_active = 0.
- Dwell timing in RUN: with D = max(cfg_dwell, 1), current_freq holds for exactly D enabled cycles. The step happens on the D-th enabled cycle. enable = 0 freezes both the counter and current_freq; no pulses are issued while frozen.
- Step arithmetic is done in FREQ_W+1 bits, so overflow and underflow are detected, never wrapped silently.
- Mode 01 (up):
  - next = cur + step.
  - If next > stop: cur ← start, sweep_wrap = 1, phase_sync = 1.
  - Otherwise cur ← next; landing exactly on stop is kept for one full dwell.
- Mode 10 (down):
  - next = cur − step.
  - If next < start or underflow: cur ← stop, sweep_wrap = 1, phase_sync = 1.
  - Otherwise cur ← next.
- Mode 11 (triangle):
  - Direction up: if cur + step ≥ stop, cur ← stop and direction ← down; otherwise cur ← cur + step.
  - Direction down: if cur − step ≤ start or underflow, cur ← start, direction ← up, sweep_wrap = 1, phase_sync = 1; otherwise cur ← cur − step.
- step_strobe = 1 on every step event, including wrap events and step = 0.
- cfg_step = 0: frequency holds and step_strobe still pulses. No wrap occurs, except when start = stop: then up/down wrap every step, and the triangle alternates direction and wraps every second step.
- A cfg_load coincident with a step event: the cfg_load wins and no step pulses are issued.
- Latency: cfg_load → current_freq is 1 cycle; a step event → current_freq is registered, so the update is visible the cycle after the D-th enabled cycle. step_strobe and sweep_wrap are aligned with the new value.

Optional Feature:
- Macro: SWEEP_CNT_EN.
- Defined: sweep_count increments on each sweep_wrap, saturates at 2^CNT_W − 1, is cleared by cfg_load and by reset.
- Undefined: the port still exists and is tied to 0; no counter logic is generated.

Test Plan:
- Reset then idle → current_freq = 0; all pulses 0; sweep_active = 0 for 20 cycles.
- cfg_load with mode 01, start = 1000, stop = 1300, step = 100, dwell = 4, enable = 1:
  - current_freq sequence is 1000, 1100, 1200, 1300, each held 4 cycles, then 1000.
  - sweep_wrap and phase_sync pulse on the return to 1000.
  - step_strobe pulses 4 times per period.
- Mode 11, start = 0, stop = 250, step = 100, dwell = 1 → 0, 100, 200, 250, 150, 50, 0. sweep_wrap pulses only on reaching 0.
- Mode 10, start = 10, stop = 0xFFFFF, step = 0x80000 → 0xFFFFF, 0x7FFFF, then underflow reload to 0xFFFFF with sweep_wrap. Also hold enable = 0 for 7 cycles mid-dwell → counter and frequency frozen, step delayed by exactly 7 cycles.
- Invalid range and fixed mode:
  - cfg_load with mode 01, start = 500, stop = 400 → cfg_err = 1, current_freq = 500, no step_strobe for 100 cycles.
  - A following cfg_load with mode 00, start = 42 → cfg_err = 0, current_freq = 42.
- Mid-sweep events and optional counter:
  - cfg_load on the same cycle as a step event → new cfg_start appears next cycle with phase_sync = 1 and no step_strobe.
  - rst_n = 0 mid-sweep → all outputs 0 next cycle.
  - With SWEEP_CNT_EN defined: 3 completed periods → sweep_count = 3.
